neo_pixel_receiver: RTL

Single-pixel WS2812 ("NeoPixel") one-wire decoder: the receive end of the serial stream produced by the strand controller. Measures high-pulse widths on `neo_in` at 50 MHz, captures the first 24 bits of a frame (GRB, MSB first) as this pixel's colour, and forwards all later bits on `neo_out` so receivers can be chained. The captured colour is committed at the latch (line-low) interval. Used as a bench/loopback checker for the strand controller and as a pixel model on FPGA.

---
 rtl/neopixel_pkg.sv | 31 +++
 rtl/counter.sv | 34 +++
 rtl/neo_pixel_receiver.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/neopixel_pkg.sv
//------------------------------------------------------------------------------
// neopixel_pkg : WS2812 timing constants, receiver state and GRB colour types
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package neopixel_pkg;

  localparam int unsigned T0H             = 18;
  localparam int unsigned T1H             = 35;
  localparam int unsigned T_BIT           = 62;
  localparam int unsigned T_LATCH_DEFAULT = 2500;
  localparam int unsigned BITS_PER_PIXEL  = 24;
  localparam int unsigned PULSE_CNT_W     = 12;

  typedef enum logic [1:0] {
    RX_SYNC = 2'd0,
    RX_LOW  = 2'd1,
    RX_HIGH = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [7:0] green;
    logic [7:0] red;
    logic [7:0] blue;
  } grb_t;

endpackage

`default_nettype wire

// File: rtl/counter.sv
//------------------------------------------------------------------------------
// counter : up-counter with synchronous clear and count enable
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module counter #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/neo_pixel_receiver.sv
//------------------------------------------------------------------------------
// neo_pixel_receiver : WS2812 single-pixel decoder with downstream forwarding
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module neo_pixel_receiver
  import neopixel_pkg::*;
#(
  parameter int unsigned T_MIN_HIGH = 5,
  parameter int unsigned T_THRESH   = 26,
  parameter int unsigned T_MAX_HIGH = 50,
  parameter int unsigned T_LATCH    = 2500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       neo_in,
  output logic       neo_out,
  output logic [7:0] green,
  output logic [7:0] red,
  output logic [7:0] blue,
  output logic       color_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam logic [12:0] c_min    = 13'(T_MIN_HIGH);
  localparam logic [12:0] c_thresh = 13'(T_THRESH);
  localparam logic [12:0] c_max    = 13'(T_MAX_HIGH);
  localparam logic [12:0] c_latch  = 13'(T_LATCH);
  localparam logic [4:0]  c_bits   = 5'(BITS_PER_PIXEL);

  logic                       r_sync1;
  logic                       r_line;
  logic                       r_neo_out;
  logic                       r_pass_en;
  logic                       r_color_valid;
  logic                       r_frame_error;
  logic [4:0]                 r_bit_cnt;
  logic [BITS_PER_PIXEL-1:0]  r_shift;
  grb_t                       r_color;
  rx_state_e                  r_state;
  rx_state_e                  w_state_nxt;

  logic [PULSE_CNT_W-1:0]     w_cnt;
  logic                       w_cnt_en;
  logic [12:0]                w_len;
  logic                       w_edge_next;
  logic                       w_rise_next;
  logic                       w_fall_next;
  logic                       w_latch;
  logic                       w_commit;
  logic                       w_bad_frame;
  logic                       w_clr_frame;
  logic                       w_bit_done;
  logic                       w_bit_val;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b0;
      r_line    <= 1'b0;
      r_neo_out <= 1'b0;
    end else begin
      r_sync1   <= neo_in;
      r_line    <= r_sync1;
      r_neo_out <= r_pass_en & r_line;
    end
  end

  // Edges are seen one cycle early (sync1 vs line), so the counter restarts
  // on the first cycle of each level and w_len includes the current cycle.
  assign w_edge_next = r_sync1 ^ r_line;
  assign w_rise_next = r_sync1 & ~r_line;
  assign w_fall_next = ~r_sync1 & r_line;
  assign w_cnt_en    = ~&w_cnt;
  assign w_len       = {1'b0, w_cnt} + 13'd1;
  assign w_latch     = ~r_line & (w_len == c_latch);

  counter #(
    .WIDTH (PULSE_CNT_W)
  ) u_pulse_cnt (
    .clk     (clock),
    .rst_n   (reset),
    .i_clear (w_edge_next),
    .i_en    (w_cnt_en),
    .o_count (w_cnt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RX_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_SYNC: begin
        if (w_latch) begin
          w_state_nxt = w_rise_next ? RX_HIGH : RX_LOW;
        end
      end
      RX_LOW: begin
        if (w_rise_next) begin
          w_state_nxt = RX_HIGH;
        end
      end
      RX_HIGH: begin
        if (w_len == c_max) begin
          w_state_nxt = RX_SYNC;
        end else if (w_fall_next) begin
          w_state_nxt = RX_LOW;
        end
      end
      default: w_state_nxt = RX_SYNC;
    endcase
  end

  always_comb begin
    w_commit    = 1'b0;
    w_bad_frame = 1'b0;
    w_clr_frame = 1'b0;
    w_bit_done  = 1'b0;
    w_bit_val   = 1'b0;
    case (r_state)
      RX_SYNC: begin
        w_clr_frame = w_latch;
      end
      RX_LOW: begin
        if (w_latch) begin
          w_clr_frame = 1'b1;
          w_commit    = (r_bit_cnt == c_bits);
          w_bad_frame = (r_bit_cnt != c_bits) && (r_bit_cnt != 5'd0);
        end
      end
      RX_HIGH: begin
        if (w_len == c_max) begin
          w_bad_frame = 1'b1;
          w_clr_frame = 1'b1;
        end else if (w_fall_next && (w_len >= c_min)) begin
          w_bit_done = 1'b1;
          w_bit_val  = (w_len >= c_thresh);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bit_cnt     <= 5'd0;
      r_shift       <= '0;
      r_pass_en     <= 1'b0;
      r_color       <= '0;
      r_color_valid <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_color_valid <= w_commit;
      r_frame_error <= w_bad_frame;
      if (w_commit) begin
        r_color <= grb_t'(r_shift);
      end
      if (w_clr_frame) begin
        r_bit_cnt <= 5'd0;
        r_pass_en <= 1'b0;
      end else if (w_bit_done && (r_bit_cnt < c_bits)) begin
        r_shift   <= {r_shift[BITS_PER_PIXEL-2:0], w_bit_val};
        r_bit_cnt <= r_bit_cnt + 5'd1;
        // Forwarding opens as the last own bit ends, ahead of the next rise.
        if (r_bit_cnt == c_bits - 5'd1) begin
          r_pass_en <= 1'b1;
        end
      end
    end
  end

  assign neo_out     = r_neo_out;
  assign green       = r_color.green;
  assign red         = r_color.red;
  assign blue        = r_color.blue;
  assign color_valid = r_color_valid;
  assign frame_error = r_frame_error;
  assign busy        = (r_state == RX_HIGH) || (r_bit_cnt != 5'd0);

endmodule

`default_nettype wire
